// File: rtl/instr_enc_pkg.sv
// Shared MIPS opcode/funct constants, mnemonic codes and the encode function
// used by the program loader (and shared with the main decoder).
package instr_enc_pkg;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_LW   = 4'd5,
    MN_SW   = 4'd6,
    MN_BEQ  = 4'd7,
    MN_ADDI = 4'd8,
    MN_ANDI = 4'd9,
    MN_XORI = 4'd10,
    MN_LUI  = 4'd11,
    MN_J    = 4'd12,
    MN_ORI  = 4'd13
  } mnem_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Returns {legal, word}; illegal codes yield legal=0 and a zero word.
  function automatic logic [32:0] encode(input logic [3:0]  mnem,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [32:0] r;
    r = 33'd0;
    case (mnem)
      MN_ADD:  r = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      MN_SUB:  r = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      MN_AND:  r = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      MN_OR:   r = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      MN_SLT:  r = {1'b1, OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      MN_LW:   r = {1'b1, OP_LW,   rs, rt, imm};
      MN_SW:   r = {1'b1, OP_SW,   rs, rt, imm};
      MN_BEQ:  r = {1'b1, OP_BEQ,  rs, rt, imm};
      MN_ADDI: r = {1'b1, OP_ADDI, rs, rt, imm};
      MN_ANDI: r = {1'b1, OP_ANDI, rs, rt, imm};
      MN_XORI: r = {1'b1, OP_XORI, rs, rt, imm};
      MN_ORI:  r = {1'b1, OP_ORI,  rs, rt, imm};
      MN_LUI:  r = {1'b1, OP_LUI,  5'd0, rt, imm};
      MN_J:    r = {1'b1, OP_J,    target};
      default: r = 33'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational mnemonic + fields to 32-bit MIPS word, with a legality flag.
module instr_encode_comb
  import instr_enc_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    {legal, word} = encode(mnem, rs, rt, rd, imm, target);
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes requests and fills instruction memory sequentially.
// Optional INSTR_ENCODER_CHECKSUM_EN adds an XOR checksum of written words.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_mnem,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     imem_we,
  output logic [31:0]              imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     err
`ifdef INSTR_ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]              checksum
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state, state_d;
  logic [31:0]     enc_word;
  logic            enc_legal;
  logic [31:0]     word_p1;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic            accept;

  instr_encode_comb u_enc (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // A handshake that coincides with clr is dropped.
  assign accept = in_valid && in_ready && !clr;

  always_comb begin
    state_d  = state;
    in_ready = (state == S_IDLE);
    imem_we  = (state == S_WRITE) && !clr;
    case (state)
      S_IDLE:  if (accept && enc_legal) state_d = S_WRITE;
      S_WRITE: state_d = (count_q == CW'(DEPTH - 1)) ? S_FULL : S_IDLE;
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Stage p1: encoded word held for the write cycle; counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_p1 <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && enc_legal)  word_p1 <= enc_word;
      if (accept && !enc_legal) err_q   <= 1'b1;
      if (state == S_WRITE)     count_q <= count_q + 1'b1;
    end
  end

  assign imem_addr  = BASE_ADDR + (32'(count_q) << 2);
  assign imem_wdata = word_p1;
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign err        = err_q;

`ifdef INSTR_ENCODER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || clr)   checksum <= '0;
    else if (imem_we) checksum <= checksum ^ word_p1;
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4) with hand-computed MIPS words.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we, full, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [$clog2(DEPTH):0] count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
`ifdef INSTR_ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg;
    in_valid = 1'b1;
  endtask

  // One-cycle request; returns at the negedge after the handshake edge.
  task automatic req(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
    @(negedge clk);
    set_req(m, rs, rt, rd, imm, tg);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"},    32'(imem_we),  32'd1);
    chk({tag, "_addr"},  imem_addr,     addr);
    chk({tag, "_wdata"}, imem_wdata,    data);
    chk({tag, "_rdy"},   32'(in_ready), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [31:0] vec_word [5];

  initial begin
    vec_word[0] = 32'h0022_1820;
    vec_word[1] = 32'h3422_00FF;
    vec_word[2] = 32'h0085_3022;
    vec_word[3] = 32'h1022_FFFE;
    vec_word[4] = 32'h0109_502A;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_addr",  imem_addr,     32'h0);
    chk("rst_wdata", imem_wdata,    32'h0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("rst_csum",  checksum,      32'h0);
`endif

    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    expect_write("add", 32'h0, 32'h0022_1820);
    @(negedge clk);
    chk("add_count", 32'(count), 32'd1);
    chk("add_we_off", 32'(imem_we), 32'd0);

    pulse_clr();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_addr",  imem_addr,  32'h0);

    req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    expect_write("lw", 32'h0, 32'h8FA8_0004);
    req(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
    expect_write("j", 32'h4, 32'h0800_0010);
    req(4'd11, 5'd7, 5'd5, 5'd9, 16'hABCD, 26'h0);
    expect_write("lui", 32'h8, 32'h3C05_ABCD);
    @(negedge clk);
    chk("lui_count", 32'(count), 32'd3);

    // Checksum run plus illegal mnemonic handling.
    pulse_clr();
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    expect_write("cs_add", 32'h0, 32'h0022_1820);
    req(4'd11, 5'd7, 5'd5, 5'd0, 16'hABCD, 26'h0);
    expect_write("cs_lui", 32'h4, 32'h3C05_ABCD);
    @(negedge clk);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("csum", checksum, 32'h3C27_B3ED);
`endif
    req(4'd15, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
    chk("ill_we",    32'(imem_we),  32'd0);
    chk("ill_err",   32'(err),      32'd1);
    chk("ill_ready", 32'(in_ready), 32'd1);
    chk("ill_count", 32'(count),    32'd2);
    @(negedge clk);
    chk("ill_we2",   32'(imem_we),  32'd0);
    chk("ill_err2",  32'(err),      32'd1);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    expect_write("post_ill", 32'h8, 32'h0022_1820);
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);

    // clr during the write cycle suppresses that write.
    pulse_clr();
    chk("clr_err", 32'(err), 32'd0);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    clr = 1'b1;
    #1;
    chk("clrw_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    chk("clrw_count", 32'(count), 32'd0);
    chk("clrw_ready", 32'(in_ready), 32'd1);

    // Handshake coinciding with clr is dropped.
    @(negedge clk);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clrhs_we",    32'(imem_we),  32'd0);
    chk("clrhs_ready", 32'(in_ready), 32'd1);

    // Back-to-back fill to DEPTH, fifth request held until clr.
    @(negedge clk);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_write($sformatf("fill%0d", k), 32'(4 * k), vec_word[k]);
      case (k)
        0: set_req(4'd13, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0);
        1: set_req(4'd1,  5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        2: set_req(4'd7,  5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0);
        default: set_req(4'd4, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
      endcase
      @(negedge clk);
      if (k < 3) chk($sformatf("fill%0d_ready", k), 32'(in_ready), 32'd1);
    end
    chk("full_flag",  32'(full),     32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count),    32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("held%0d_we", k), 32'(imem_we), 32'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("refill_count", 32'(count),    32'd0);
    chk("refill_full",  32'(full),     32'd0);
    chk("refill_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    expect_write("fifth", 32'h0, vec_word[4]);
    @(negedge clk);
    chk("fifth_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the main decoder: turns symbolic instruction requests (mnemonic + register/immediate fields) into 32-bit MIPS machine words.
- Writes each word sequentially into instruction memory through a single write port.
- Used as the on-chip program loader that fills instruction memory from a test/boot stream before the core is released from reset.
- Accepts requests over a valid/ready handshake, tracks the fill address, and reports completion and error status.

Parameters:
- DEPTH, 64: instruction memory capacity in words; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  restart fill at BASE_ADDR; clears count and error
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_mnem  in  4  mnemonic code (instr_enc_pkg::mnem_t)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate
- in_target  in  26  jump target
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  32  byte address of the write
- imem_wdata  out  32  encoded word
- count  out  $clog2(DEPTH)+1  words written since reset/clr
- full  out  1  count == DEPTH
- err  out  1  sticky; set by an illegal mnemonic

Behaviour:
- Reset values: in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, FSM=S_IDLE.
- FSM S_IDLE: in_ready=1. A handshake (in_valid & in_ready) latches the encoded word and moves to S_WRITE.
- FSM S_WRITE: imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*count (pre-increment) and imem_wdata = the encoded word; in_ready=0. Next cycle count increments; go to S_FULL if the new count == DEPTH, else S_IDLE.
- FSM S_FULL: in_ready=0, full=1. Only rst or clr leaves this state.
- Latency: a request accepted in cycle N is written in cycle N+1. Peak throughput is one word per 2 cycles.
- Encoding, R-type (op 000000, shamt 0): funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010. Word = {op,rs,rt,rd,5'b0,funct}.
- Encoding, I-type: {op,rs,rt,imm} with op LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, XORI 001110, ORI 001101, LUI 001111. For LUI the rs field is forced to 0.
- Encoding, J-type: J = {000010,target}.
- Unused input fields are ignored (e.g. rd for I-type).
- Illegal mnemonic (codes 14, 15): the request is still accepted (handshake completes) but no write occurs; err is set; FSM stays in S_IDLE; count is unchanged.
- clr: synchronous, with priority over everything except rst. Returns to S_IDLE with count=0, full=0, err=0, imem_we=0 the next cycle. A handshake coinciding with clr is dropped. clr during S_WRITE suppresses that write.
- imem_addr wraps never; full blocks further writes instead.
- in_valid with in_ready=0 must be held by the source; the encoder samples only on handshake.

Optional Feature:
- Macro: INSTR_ENCODER_CHECKSUM_EN.
- When defined: adds output checksum [31:0], the XOR of every word actually written since reset/clr. Reset value 0; updated in the cycle after each imem_we.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package instr_enc_pkg holds: mnem_t enum (ADD=0 … ORI=13); opcode and funct localparams (shared with the main decoder); and an encode function returning {legal, word[31:0]}.
- One sub-module, instr_encode_comb: purely combinational mnemonic+fields to word/legal. The top keeps the FSM, address counter, and status flags.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 -> cycle+1: imem_we=1, addr 0x0, wdata 0x00221820; count=1.
- LW rs=29 rt=8 imm=0x0004, then J target=0x0000010 -> wdata 0x8FA80004 at 0x0, 0x08000010 at 0x4; in_ready low on each write cycle.
- LUI rs=7 rt=5 imm=0xABCD -> wdata 0x3C05ABCD (rs forced 0).
- Mnemonic 15 -> no imem_we; err=1 sticky; the next legal request is still written at the unchanged address.
- DEPTH=4, five back-to-back requests -> 4 writes (0x0–0xC), full=1, in_ready=0, fifth request held; clr -> count=0, fifth written at 0x0.
- With INSTR_ENCODER_CHECKSUM_EN defined: writes 0x00221820 and 0x3C05ABCD -> checksum 0x3C27B3ED.
